// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  localparam int WB_SEL_W = 4;

  // Input is assumed one-hot. OR-ing the indices of the set bits gives the
  // index without a priority chain.
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational round-robin selector: first requester at or after last+1.
module rr_picker #(
  parameter int NM = 4,
  parameter int LW = 2
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last,
  output logic [NM-1:0] pick,
  output logic          valid
);

  always_comb begin
    int  idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NM; i++) begin
      idx = (int'(last) + 1 + i) % NM;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/wb_arb_rr.sv
// Round-robin Wishbone arbiter: NM masters share one slave port, grant held
// for the whole cyc, with a per-access watchdog that turns a hung slave into err.
module wb_arb_rr
  import wb_arb_pkg::*;
#(
  parameter int NM  = 4,
  parameter int AW  = 8,
  parameter int DW  = 8,
  parameter int TMO = 255
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NM-1:0]          m_cyc_i,
  input  logic [NM-1:0]          m_stb_i,
  input  logic [NM-1:0]          m_we_i,
  input  logic [NM*AW-1:0]       m_adr_i,
  input  logic [NM*DW-1:0]       m_dat_i,
  input  logic [NM*WB_SEL_W-1:0] m_sel_i,
  output logic [DW-1:0]          m_dat_o,
  output logic [NM-1:0]          m_ack_o,
  output logic [NM-1:0]          m_err_o,
  output logic [NM-1:0]          m_rty_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [AW-1:0]          s_adr_o,
  output logic [DW-1:0]          s_dat_o,
  output logic [WB_SEL_W-1:0]    s_sel_o,
  input  logic [DW-1:0]          s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_rty_i,
  output logic [NM-1:0]          gnt_o,
  output logic                   tmo_o
);

  // state    | meaning
  // ST_IDLE  | no owner, slave port quiet, arbitrate among cyc requests
  // ST_OWNED | grant held by gnt_q until that master drops cyc

  localparam int LW  = $clog2(NM);
  localparam int WDW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  arb_state_e     state_q, state_d;
  logic [NM-1:0]  gnt_q, gnt_d;
  logic [LW-1:0]  last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic [NM-1:0]  pick;
  logic           pick_valid;
  logic [7:0]     pick_ext;
  logic           cyc_g, stb_g, term, fire;

  rr_picker #(
    .NM (NM),
    .LW (LW)
  ) u_picker (
    .req   (m_cyc_i),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(NM - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    wd_d     = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m_dat_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_rty_o  = '0;
    tmo_o    = 1'b0;
    cyc_g    = 1'b0;
    stb_g    = 1'b0;
    term     = 1'b0;
    fire     = 1'b0;
    pick_ext = '0;
    pick_ext[NM-1:0] = pick;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick;
          last_d  = LW'(onehot2idx(pick_ext));
          state_d = ST_OWNED;
        end
      end
      ST_OWNED: begin
        cyc_g = |(m_cyc_i & gnt_q);
        stb_g = |(m_stb_i & gnt_q);
        term  = s_ack_i | s_err_i | s_rty_i;
        // A real slave termination always beats the watchdog.
        fire  = (TMO != 0) && (wd_q == WDW'(TMO)) && !term;

        s_cyc_o = cyc_g;
        s_stb_o = stb_g & ~fire;
        for (int k = 0; k < NM; k++) begin
          if (gnt_q[k]) begin
            s_we_o  = m_we_i[k];
            s_adr_o = m_adr_i[k*AW +: AW];
            s_dat_o = m_dat_i[k*DW +: DW];
            s_sel_o = m_sel_i[k*WB_SEL_W +: WB_SEL_W];
          end
        end

        m_dat_o = s_dat_i;
        m_ack_o = gnt_q & {NM{s_ack_i}};
        m_rty_o = gnt_q & {NM{s_rty_i}};
        m_err_o = gnt_q & {NM{s_err_i | fire}};
        tmo_o   = fire;

        if (stb_g && !fire && !term) begin
          wd_d = (wd_q == '1) ? wd_q : wd_q + 1'b1;
        end

        if (!cyc_g) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt_o = gnt_q;

endmodule

// File: tb/tb_wb_arb_rr.sv
// Directed bench for wb_arb_rr with NM=4 and a short watchdog (TMO=5).
module tb_wb_arb_rr;

  localparam int NM  = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 5;

  logic              hclk = 1'b0;
  logic              hreset;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*4-1:0]   m_sel_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [3:0]        s_sel_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [NM-1:0]     gnt_o;
  logic              tmo_o;

  int checks = 0;
  int errors = 0;

  wb_arb_rr #(.NM(NM), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .s_rty_i (s_rty_i),
    .gnt_o   (gnt_o),
    .tmo_o   (tmo_o)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    @(negedge hclk);
  endtask

  logic [3:0] exp_g [6];

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    hreset  = 1'b1;
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    m_adr_i = 32'h7856_3412;
    m_dat_i = 32'h4433_2211;
    m_sel_i = 16'h8421;
    s_dat_i = 8'h77;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;

    // reset state; s_dat_i must be gated off m_dat_o
    tick(); tick(); settle();
    chk("rst_gnt",   gnt_o,   4'h0);
    chk("rst_scyc",  s_cyc_o, 1'b0);
    chk("rst_sstb",  s_stb_o, 1'b0);
    chk("rst_sadr",  s_adr_o, 8'h00);
    chk("rst_mdat",  m_dat_o, 8'h00);
    chk("rst_mack",  m_ack_o, 4'h0);
    chk("rst_tmo",   tmo_o,   1'b0);

    // master 0 read of 0x12, ack in 2nd owned cycle
    tick(); hreset = 1'b0; m_cyc_i = 4'b0001; m_stb_i = 4'b0001; settle();
    chk("rd_latency_gnt", gnt_o, 4'h0);
    tick(); settle();
    chk("rd_gnt",    gnt_o,   4'b0001);
    chk("rd_scyc",   s_cyc_o, 1'b1);
    chk("rd_sstb",   s_stb_o, 1'b1);
    chk("rd_sadr",   s_adr_o, 8'h12);
    chk("rd_swe",    s_we_o,  1'b0);
    chk("rd_ssel",   s_sel_o, 4'h1);
    chk("rd_noack",  m_ack_o, 4'h0);
    tick(); s_ack_i = 1'b1; s_dat_i = 8'hA5; settle();
    chk("rd_ack",    m_ack_o, 4'b0001);
    chk("rd_mdat",   m_dat_o, 8'hA5);
    tick(); s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; settle();
    chk("rd_ack_once", m_ack_o, 4'h0);
    chk("rd_hold_gnt", gnt_o,   4'b0001);
    tick(); settle();
    chk("rd_release", gnt_o, 4'h0);

    // round robin among 0,1,3 after a fresh reset
    tick(); hreset = 1'b1; settle();
    tick(); hreset = 1'b0; m_cyc_i = 4'b1011; settle();
    chk("rr_idle0", gnt_o, 4'h0);
    for (int i = 0; i < 6; i++) begin
      tick(); m_cyc_i = 4'b1011 & ~exp_g[i]; settle();
      chk($sformatf("rr_gnt%0d", i), gnt_o, exp_g[i]);
      tick(); m_cyc_i = (i == 5) ? 4'b0000 : 4'b1011; settle();
      chk($sformatf("rr_idle%0d", i + 1), gnt_o, 4'h0);
    end

    // watchdog: master 2, slave silent, fires at stb+5 and again at stb+11
    tick(); m_cyc_i = 4'b0100; m_stb_i = 4'b0100; settle();
    chk("wd_idle", gnt_o, 4'h0);
    tick(); settle();
    chk("wd_gnt",  gnt_o,   4'b0100);
    chk("wd_sadr", s_adr_o, 8'h56);
    chk("wd_stb0", s_stb_o, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      tick(); settle();
      chk($sformatf("wd_tmo_t%0d", k),  tmo_o,   (k == 5 || k == 11) ? 1'b1 : 1'b0);
      chk($sformatf("wd_err_t%0d", k),  m_err_o, (k == 5 || k == 11) ? 4'b0100 : 4'b0000);
      chk($sformatf("wd_stb_t%0d", k),  s_stb_o, (k == 5 || k == 11) ? 1'b0 : 1'b1);
    end

    // ack arriving exactly when wd reaches TMO
    for (int k = 12; k < 17; k++) tick();
    tick(); s_ack_i = 1'b1; settle();
    chk("race_ack", m_ack_o, 4'b0100);
    chk("race_tmo", tmo_o,   1'b0);
    chk("race_err", m_err_o, 4'h0);
    chk("race_stb", s_stb_o, 1'b1);

    // master 2 drops cyc, late ack dropped, pending master 1 granted
    tick(); s_ack_i = 1'b0; m_cyc_i = 4'b0110; m_stb_i = 4'b0110; settle();
    chk("drop_tmo_after_ack", tmo_o, 1'b0);
    chk("drop_no_handover",   gnt_o, 4'b0100);
    tick(); m_cyc_i = 4'b0010; m_stb_i = 4'b0010; settle();
    chk("drop_scyc", s_cyc_o, 1'b0);
    chk("drop_ack0", m_ack_o, 4'h0);
    tick(); s_ack_i = 1'b1; settle();
    chk("drop_late_ack", m_ack_o, 4'h0);
    chk("drop_idle_gnt", gnt_o,   4'h0);
    tick(); s_ack_i = 1'b0; settle();
    chk("drop_gnt1", gnt_o,   4'b0010);
    chk("drop_sadr", s_adr_o, 8'h34);

    // reset mid-tenure of master 1
    tick(); hreset = 1'b1; settle();
    tick(); s_ack_i = 1'b1; s_dat_i = 8'h5A; settle();
    chk("mrst_gnt",  gnt_o,   4'h0);
    chk("mrst_scyc", s_cyc_o, 1'b0);
    chk("mrst_sstb", s_stb_o, 1'b0);
    chk("mrst_sadr", s_adr_o, 8'h00);
    chk("mrst_mack", m_ack_o, 4'h0);
    chk("mrst_mdat", m_dat_o, 8'h00);
    chk("mrst_tmo",  tmo_o,   1'b0);
    tick(); hreset = 1'b0; s_ack_i = 1'b0; m_cyc_i = 4'b0011; m_stb_i = 4'b0011;
    m_we_i = 4'b0001; settle();
    chk("mrst_idle", gnt_o, 4'h0);
    tick(); settle();
    chk("mrst_gnt0", gnt_o,   4'b0001);
    chk("wr_swe",    s_we_o,  1'b1);
    chk("wr_sdat",   s_dat_o, 8'h11);
    chk("wr_ssel",   s_sel_o, 4'h1);
    tick(); s_err_i = 1'b1; settle();
    chk("wr_err",    m_err_o, 4'b0001);
    chk("wr_noack",  m_ack_o, 4'h0);
    tick(); s_err_i = 1'b0; s_rty_i = 1'b1; settle();
    chk("wr_rty",    m_rty_o, 4'b0001);
    chk("wr_rty_err", m_err_o, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not terminate");
  end

endmodule
